// File: rtl/canvas_writer.sv
// Publishes game statistics and per-key status bytes to a canvas RAM over an Avalon-MM write
// master; only bytes that changed since their last write are sent.
module canvas_writer #(
    parameter int unsigned FORCE_FULL = 0,
    parameter logic [5:0]  KEY_BASE   = 6'h05
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit,
    input  logic [23:0] score,
    input  logic [15:0] acc,
    input  logic [15:0] npure,
    input  logic [15:0] nfar,
    input  logic [15:0] nlost,
    input  logic [15:0] ncombo,
    input  logic [1:0]  gst_state,
    input  logic [1:0]  gst_fig,
    input  logic [7:0]  life,
    input  logic [7:0]  skill,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [5:0]  key_idx,
    input  logic [7:0]  key_stat,
    output logic        avm_cs,
    output logic        avm_wren,
    output logic [5:0]  avm_addr,
    output logic [7:0]  avm_wdata,
    input  logic        avm_waitrequest,
    output logic        busy
);

    typedef enum logic [0:0] {StSelect, StIssue} state_e;

    state_e            state_q, state_d;
    logic [5:0]        addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [15:0]       dirty_q, dirty_d;
    logic              pending_q, pending_d;
    logic              valid_q, valid_d;
    logic [3:0]        slot_q, slot_d;
    logic              is_stat_q, is_stat_d;
    logic [15:0][7:0]  shadow_q, last_q;
    logic [15:0][7:0]  snap;
    logic [3:0]        low_slot;
    logic              key_ok;
    logic              snap_en, done_en;

    function automatic logic [5:0] slot_addr(input logic [3:0] s);
        if (s < 4'd5)      return {2'b00, s};
        else if (s < 4'd8) return 6'h2B + {2'b00, s};
        else               return 6'h30 + {2'b00, s};
    endfunction

    always_comb begin
        snap[0]  = score[7:0];
        snap[1]  = score[15:8];
        snap[2]  = score[23:16];
        snap[3]  = acc[7:0];
        snap[4]  = acc[15:8];
        snap[5]  = {4'b0000, gst_state, gst_fig};
        snap[6]  = life;
        snap[7]  = skill;
        snap[8]  = npure[7:0];
        snap[9]  = npure[15:8];
        snap[10] = nfar[7:0];
        snap[11] = nfar[15:8];
        snap[12] = nlost[7:0];
        snap[13] = nlost[15:8];
        snap[14] = ncombo[7:0];
        snap[15] = ncombo[15:8];
    end

    always_comb begin
        low_slot = '0;
        for (int i = 15; i >= 0; i--) begin
            if (dirty_q[i]) low_slot = 4'(i);
        end
    end

    // Indices 43..45 would alias the stat bytes at 0x30..0x32.
    assign key_ok = (key_idx <= 6'd42) || (key_idx >= 6'd46 && key_idx <= 6'd50);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dirty_d   = dirty_q;
        pending_d = pending_q | commit;
        valid_d   = valid_q;
        slot_d    = slot_q;
        is_stat_d = is_stat_q;
        snap_en   = 1'b0;
        done_en   = 1'b0;
        unique case (state_q)
            StSelect: begin
                if (key_valid) begin
                    if (key_ok) begin
                        state_d   = StIssue;
                        addr_d    = KEY_BASE + key_idx;
                        wdata_d   = key_stat;
                        is_stat_d = 1'b0;
                    end
                end else if (|dirty_q) begin
                    state_d   = StIssue;
                    addr_d    = slot_addr(low_slot);
                    wdata_d   = shadow_q[low_slot];
                    slot_d    = low_slot;
                    is_stat_d = 1'b1;
                end else if (pending_q) begin
                    // A commit arriving in this very cycle stays pending for the next snapshot.
                    snap_en   = 1'b1;
                    pending_d = commit;
                    valid_d   = 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        dirty_d[i] = (FORCE_FULL != 0) || !valid_q || (snap[i] != last_q[i]);
                    end
                end
            end
            StIssue: begin
                if (!avm_waitrequest) begin
                    state_d = StSelect;
                    if (is_stat_q) begin
                        dirty_d[slot_q] = 1'b0;
                        done_en         = 1'b1;
                    end
                end
            end
            default: state_d = StSelect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StSelect;
            addr_q    <= '0;
            wdata_q   <= '0;
            dirty_q   <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            slot_q    <= '0;
            is_stat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            slot_q    <= slot_d;
            is_stat_q <= is_stat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && snap_en) shadow_q <= snap;
        if (reset && done_en) last_q[slot_q] <= shadow_q[slot_q];
    end

    assign avm_cs    = (state_q == StIssue);
    assign avm_wren  = avm_cs;
    assign avm_addr  = addr_q;
    assign avm_wdata = wdata_q;
    assign key_ready = reset && (state_q == StSelect);
    assign busy      = reset && ((state_q == StIssue) || pending_q || (|dirty_q));

endmodule
